tc2_side_request_conditioner: RTL and testbench
===============================================

TC2_SIDE_REQUEST_CONDITIONER -- requirements
Module: tc2_side_request_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles needed before a cleaned input changes; legal range 1..15.
REQ-002 Parameter WAIT_LIMIT, default 64: PENDING cycles before urgent asserts; legal range 1..255.
REQ-003 clk  input  1  single clock for all logic, rising edge.
REQ-004 async_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 sensor_raw  input  1  side-road vehicle loop detector; asynchronous to clk; may bounce.
REQ-006 ped_raw  input  1  side-road pedestrian button; asynchronous to clk; may bounce.
REQ-007 SG  input  1  side-green lamp from the light controller; synchronous to clk.
REQ-008 side_req  output  1  service request to the light controller; high while PENDING.
REQ-009 ped_req  output  1  high while PENDING and the pedestrian latch is set.
REQ-010 urgent  output  1  PENDING wait has reached WAIT_LIMIT.
REQ-011 req_count  output  8  number of serviced requests, saturating.
REQ-012 sensor_clean  output  1  debounced vehicle-detector level, for observation.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-014 Debounce, per input:
- counter increments while the synchronized value differs from the clean value;
- counter clears on any cycle where they match;
- clean value toggles, and the counter clears, on the edge where the counter would reach DEBOUNCE_CYCLES.
REQ-015 Edge detect: a 0->1 transition of a clean input SHALL set that input's latch (veh_latch, ped_latch); 1->0 transitions SHALL be ignored.
REQ-016 Latency: a clean raw rise sampled at edge k SHALL give sensor_clean=1 after edge k+1+DEBOUNCE_CYCLES and side_req=1 after edge k+2+DEBOUNCE_CYCLES (6 edges with default DEBOUNCE_CYCLES=4).
REQ-017 FSM states: IDLE, PENDING, SERVING.
REQ-018 IDLE -> PENDING on the cycle after either latch is set.
REQ-019 PENDING -> SERVING when SG=1.
- On this transition both latches clear and req_count increments, saturating at 255.
REQ-020 SERVING -> on SG falling (SG=0 with previous SG=1):
- to PENDING if any latch was set during SERVING;
- otherwise to IDLE.
REQ-021 A rising edge of a clean input during SERVING SHALL set its latch and SHALL NOT shorten or extend SERVING.
REQ-022 Simultaneous events: a clean rising edge on the same cycle SG falls SHALL be captured, and the FSM SHALL go to PENDING.
REQ-023 SG already high when the FSM enters PENDING SHALL move the FSM to SERVING on the next edge.
REQ-024 Wait counter:
- counts cycles spent in PENDING;
- saturates at WAIT_LIMIT;
- urgent = (wait counter == WAIT_LIMIT);
- clears when PENDING is exited.
REQ-025 side_req, ped_req and urgent SHALL be decoded only from registered state; no combinational path from SG or raw inputs to any output.
REQ-026 SG=1 in IDLE SHALL have no effect.

Reset
REQ-027 async_reset_n=0 SHALL immediately force:
- FSM to IDLE;
- all synchronizer flops, clean values, debounce counters, latches, wait counter and req_count to 0;
- therefore all outputs to 0.
REQ-028 Reset asserted mid-operation (PENDING or SERVING) SHALL discard any pending request.
REQ-029 After async_reset_n returns high, raw inputs already high SHALL produce a rising edge through the normal debounce path.

Verification
REQ-030 Clean sensor_raw pulse 10 cycles, SG=0 -> sensor_clean=1 at edge k+5, side_req=1 at edge k+6, ped_req=0.
REQ-031 sensor_raw toggling every 2 cycles for 20 cycles with DEBOUNCE_CYCLES=4 -> sensor_clean stays 0, side_req stays 0.
REQ-032 ped_raw press, SG held 0 for 70 cycles -> side_req=1, ped_req=1, urgent=1 exactly WAIT_LIMIT=64 cycles after PENDING entry; then SG=1 -> next edge: side_req=0, urgent=0, req_count=1.
REQ-033 In SERVING, vehicle edge arrives, then SG falls -> FSM goes to PENDING, side_req=1 on the edge after SG falls; a second run with no edge during SERVING -> FSM goes to IDLE.
REQ-034 async_reset_n pulsed low while PENDING with req_count=3 -> all outputs 0 immediately, without waiting for a clock edge; with sensor_raw held high, side_req reasserts DEBOUNCE_CYCLES+3 edges after reset release.
REQ-035 300 request/serve cycles -> req_count saturates at 255 and does not wrap.

Source files
------------

// File: rtl/tc2_side_request_conditioner.sv
// Side-road request conditioner: sync + debounce detector/button,
// latch rising edges and hold a service request until side-green.
module tc2_side_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WAIT_LIMIT      = 64
) (
  input  logic       clk,
  input  logic       async_reset_n,
  input  logic       sensor_raw,
  input  logic       ped_raw,
  input  logic       SG,
  output logic       side_req,
  output logic       ped_req,
  output logic       urgent,
  output logic [7:0] req_count,
  output logic       sensor_clean
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_CYCLES);
  localparam logic [7:0] WL  = 8'(WAIT_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] raw;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] clean_q, clean_d;
  logic [3:0] cnt_q [2];
  logic [3:0] cnt_d [2];
  logic [1:0] rise;
  logic       veh_latch_q, veh_latch_d;
  logic       ped_latch_q, ped_latch_d;
  logic       sg_q;
  logic [7:0] wait_q, wait_d;
  logic [7:0] count_q, count_d;
  logic       any_latch;
  logic       sg_fall;
  logic       serve;

  // Index 0 is the vehicle detector, index 1 the pedestrian button.
  assign raw = {ped_raw, sensor_raw};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rise[i]    = 1'b0;
      cnt_d[i]   = 4'd0;
      clean_d[i] = clean_q[i];
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] + 4'd1 == DEB) begin
          clean_d[i] = ~clean_q[i];
          rise[i]    = ~clean_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign any_latch = veh_latch_q | ped_latch_q;
  assign sg_fall   = ~SG & sg_q;
  assign serve     = (state_q == PENDING) & SG;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (any_latch) state_d = PENDING;
      end
      PENDING: begin
        if (SG) state_d = SERVING;
      end
      SERVING: begin
        // An edge landing on the same cycle SG drops still counts.
        if (sg_fall) begin
          if (any_latch | (|rise)) state_d = PENDING;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    veh_latch_d = veh_latch_q | rise[0];
    ped_latch_d = ped_latch_q | rise[1];
    count_d     = count_q;
    if (serve) begin
      veh_latch_d = rise[0];
      ped_latch_d = rise[1];
      if (count_q != 8'hFF) count_d = count_q + 8'd1;
    end
  end

  always_comb begin
    wait_d = 8'd0;
    if (state_q == PENDING && state_d == PENDING) begin
      if (wait_q == WL) wait_d = wait_q;
      else              wait_d = wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      clean_q     <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      veh_latch_q <= 1'b0;
      ped_latch_q <= 1'b0;
      sg_q        <= 1'b0;
      wait_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      clean_q     <= clean_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      veh_latch_q <= veh_latch_d;
      ped_latch_q <= ped_latch_d;
      sg_q        <= SG;
      wait_q      <= wait_d;
      count_q     <= count_d;
    end
  end

  assign side_req     = (state_q == PENDING);
  assign ped_req      = (state_q == PENDING) & ped_latch_q;
  assign urgent       = (wait_q == WL);
  assign req_count    = count_q;
  assign sensor_clean = clean_q[0];

endmodule

// File: tb/tb_tc2_side_request_conditioner.sv
// Directed bench for tc2_side_request_conditioner (default parameters).
module tb_tc2_side_request_conditioner;

  logic       clk = 1'b0;
  logic       async_reset_n = 1'b0;
  logic       sensor_raw = 1'b0;
  logic       ped_raw = 1'b0;
  logic       SG = 1'b0;
  logic       side_req;
  logic       ped_req;
  logic       urgent;
  logic [7:0] req_count;
  logic       sensor_clean;

  int nvec = 0;
  int nerr = 0;

  tc2_side_request_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .WAIT_LIMIT(64)
  ) dut (
    .clk(clk),
    .async_reset_n(async_reset_n),
    .sensor_raw(sensor_raw),
    .ped_raw(ped_raw),
    .SG(SG),
    .side_req(side_req),
    .ped_req(ped_req),
    .urgent(urgent),
    .req_count(req_count),
    .sensor_clean(sensor_clean)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    async_reset_n = 1'b0;
    sensor_raw = 1'b0;
    ped_raw = 1'b0;
    SG = 1'b0;
    tick();
    tick();
    async_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    async_reset_n = 1'b0;
    #3;
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL reset_side got %b exp 0", side_req); end
    nvec++; if (ped_req !== 1'b0) begin nerr++; $display("FAIL reset_ped got %b exp 0", ped_req); end
    nvec++; if (urgent !== 1'b0) begin nerr++; $display("FAIL reset_urgent got %b exp 0", urgent); end
    nvec++; if (req_count !== 8'd0) begin nerr++; $display("FAIL reset_count got %0d exp 0", req_count); end
    nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL reset_clean got %b exp 0", sensor_clean); end
    do_reset();
  endtask

  task automatic test_clean_pulse();
    do_reset();
    sensor_raw = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (i == 4) begin
        nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL pulse_clean_k4 got %b exp 0", sensor_clean); end
      end
      if (i == 5) begin
        nvec++; if (sensor_clean !== 1'b1) begin nerr++; $display("FAIL pulse_clean_k5 got %b exp 1", sensor_clean); end
        nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL pulse_side_k5 got %b exp 0", side_req); end
      end
      if (i == 6) begin
        nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL pulse_side_k6 got %b exp 1", side_req); end
        nvec++; if (ped_req !== 1'b0) begin nerr++; $display("FAIL pulse_ped_k6 got %b exp 0", ped_req); end
      end
    end
    sensor_raw = 1'b0;
    SG = 1'b1;
    tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL pulse_serve_side got %b exp 0", side_req); end
    nvec++; if (req_count !== 8'd1) begin nerr++; $display("FAIL pulse_serve_count got %0d exp 1", req_count); end
    SG = 1'b0;
    repeat (9) tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL pulse_idle_side got %b exp 0", side_req); end
    nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL pulse_fall_clean got %b exp 0", sensor_clean); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sensor_raw = ((i / 2) % 2 == 0);
      tick();
      nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL bounce_clean_%0d got %b exp 0", i, sensor_clean); end
      nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL bounce_side_%0d got %b exp 0", i, side_req); end
    end
    sensor_raw = 1'b0;
    repeat (8) tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL bounce_after_side got %b exp 0", side_req); end
  endtask

  task automatic test_idle_sg();
    do_reset();
    SG = 1'b1;
    repeat (5) tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL idlesg_side got %b exp 0", side_req); end
    nvec++; if (req_count !== 8'd0) begin nerr++; $display("FAIL idlesg_count got %0d exp 0", req_count); end
    sensor_raw = 1'b1;
    tick();
    repeat (6) tick();
    nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL sghigh_pending got %b exp 1", side_req); end
    tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL sghigh_serve_side got %b exp 0", side_req); end
    nvec++; if (req_count !== 8'd1) begin nerr++; $display("FAIL sghigh_serve_count got %0d exp 1", req_count); end
    SG = 1'b0;
    repeat (2) tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL sghigh_idle_side got %b exp 0", side_req); end
  endtask

  task automatic test_ped_wait();
    do_reset();
    ped_raw = 1'b1;
    tick();
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (i == 20) ped_raw = 1'b0;
      if (i == 6) begin
        nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL ped_side got %b exp 1", side_req); end
        nvec++; if (ped_req !== 1'b1) begin nerr++; $display("FAIL ped_ped got %b exp 1", ped_req); end
      end
      if (i == 69) begin
        nvec++; if (urgent !== 1'b0) begin nerr++; $display("FAIL urgent_early got %b exp 0", urgent); end
      end
      if (i == 70) begin
        nvec++; if (urgent !== 1'b1) begin nerr++; $display("FAIL urgent_at_limit got %b exp 1", urgent); end
        nvec++; if (ped_req !== 1'b1) begin nerr++; $display("FAIL ped_hold got %b exp 1", ped_req); end
      end
    end
    SG = 1'b1;
    tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL ped_serve_side got %b exp 0", side_req); end
    nvec++; if (urgent !== 1'b0) begin nerr++; $display("FAIL ped_serve_urgent got %b exp 0", urgent); end
    nvec++; if (req_count !== 8'd1) begin nerr++; $display("FAIL ped_serve_count got %0d exp 1", req_count); end
    nvec++; if (ped_req !== 1'b0) begin nerr++; $display("FAIL ped_serve_ped got %b exp 0", ped_req); end
    SG = 1'b0;
    repeat (2) tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL ped_idle_side got %b exp 0", side_req); end
  endtask

  task automatic test_serve_reentry();
    do_reset();
    sensor_raw = 1'b1;
    repeat (7) tick();
    nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL reent_pending got %b exp 1", side_req); end
    SG = 1'b1;
    tick();
    nvec++; if (req_count !== 8'd1) begin nerr++; $display("FAIL reent_count1 got %0d exp 1", req_count); end
    sensor_raw = 1'b0;
    repeat (8) tick();
    sensor_raw = 1'b1;
    repeat (8) tick();
    nvec++; if (sensor_clean !== 1'b1) begin nerr++; $display("FAIL reent_clean got %b exp 1", sensor_clean); end
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL reent_still_serving got %b exp 0", side_req); end
    SG = 1'b0;
    tick();
    nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL reent_back_pending got %b exp 1", side_req); end
    SG = 1'b1;
    tick();
    nvec++; if (req_count !== 8'd2) begin nerr++; $display("FAIL reent_count2 got %0d exp 2", req_count); end
    sensor_raw = 1'b0;
    repeat (10) tick();
    SG = 1'b0;
    tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL noedge_idle got %b exp 0", side_req); end
    tick();
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL noedge_idle2 got %b exp 0", side_req); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ped_raw = 1'b1;
    repeat (7) tick();
    nvec++; if (ped_req !== 1'b1) begin nerr++; $display("FAIL simul_ped_pending got %b exp 1", ped_req); end
    ped_raw = 1'b0;
    SG = 1'b1;
    tick();
    repeat (8) tick();
    sensor_raw = 1'b1;
    tick();
    repeat (4) tick();
    nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL simul_clean_before got %b exp 0", sensor_clean); end
    SG = 1'b0;
    tick();
    nvec++; if (sensor_clean !== 1'b1) begin nerr++; $display("FAIL simul_clean_edge got %b exp 1", sensor_clean); end
    nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL simul_pending got %b exp 1", side_req); end
    nvec++; if (ped_req !== 1'b0) begin nerr++; $display("FAIL simul_ped got %b exp 0", ped_req); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      ped_raw = 1'b1;
      repeat (7) tick();
      ped_raw = 1'b0;
      SG = 1'b1;
      tick();
      repeat (8) tick();
      SG = 1'b0;
      tick();
      repeat (2) tick();
    end
    sensor_raw = 1'b1;
    repeat (7) tick();
    nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL mid_pending got %b exp 1", side_req); end
    nvec++; if (req_count !== 8'd3) begin nerr++; $display("FAIL mid_count got %0d exp 3", req_count); end
    #2;
    async_reset_n = 1'b0;
    #1;
    nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL mid_rst_side got %b exp 0", side_req); end
    nvec++; if (req_count !== 8'd0) begin nerr++; $display("FAIL mid_rst_count got %0d exp 0", req_count); end
    nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL mid_rst_clean got %b exp 0", sensor_clean); end
    nvec++; if (ped_req !== 1'b0 || urgent !== 1'b0) begin nerr++; $display("FAIL mid_rst_ped_urg got %b%b exp 00", ped_req, urgent); end
    tick();
    tick();
    async_reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) begin
        nvec++; if (sensor_clean !== 1'b0) begin nerr++; $display("FAIL rel_clean_e5 got %b exp 0", sensor_clean); end
      end
      if (i == 6) begin
        nvec++; if (sensor_clean !== 1'b1) begin nerr++; $display("FAIL rel_clean_e6 got %b exp 1", sensor_clean); end
        nvec++; if (side_req !== 1'b0) begin nerr++; $display("FAIL rel_side_e6 got %b exp 0", side_req); end
      end
      if (i == 7) begin
        nvec++; if (side_req !== 1'b1) begin nerr++; $display("FAIL rel_side_e7 got %b exp 1", side_req); end
      end
    end
  endtask

  task automatic test_saturate();
    logic got;
    do_reset();
    for (int n = 1; n <= 300; n++) begin
      sensor_raw = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
        tick();
        got = side_req;
      end
      nvec++; if (!got) begin nerr++; $display("FAIL sat_timeout iter %0d got 0 exp side_req 1", n); end
      SG = 1'b1;
      sensor_raw = 1'b0;
      tick();
      repeat (7) tick();
      SG = 1'b0;
      tick();
      if (n == 254 || n == 255 || n == 256 || n == 300) begin
        nvec++;
        if (req_count !== ((n > 255) ? 8'd255 : 8'(n))) begin
          nerr++;
          $display("FAIL sat_count iter %0d got %0d exp %0d", n, req_count, (n > 255) ? 255 : n);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_pulse();
    test_bounce();
    test_idle_sg();
    test_ped_wait();
    test_serve_reentry();
    test_simultaneous();
    test_reset_mid();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
